mem_system: RTL and testbench

- Parametrised program/data memory subsystem that replaces the fixed 1024x16 ROM/RAM pair and the clock-gated RAM write-enable.
- Provides a fetch port and a data port with req/ready handshakes and configurable wait states.
- Supports split (Harvard) or unified (single-array, arbitrated) storage.
- Provides a loader port that writes program memory while the CPU is held off.

---
 rtl/mem_system.sv | 196 +++++++++++++++++++
 tb/tb_mem_system.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_system.sv
// Program/data memory subsystem: fetch and data ports with req/ready handshakes,
// configurable wait states, split or unified storage, and a program loader port.
module mem_system #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned UNIFIED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  input  logic                  ld_en,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [2:0]            WS      = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  localparam int unsigned           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                i_state_q, i_state_d;
  state_e                d_state_q, d_state_d;
  logic [2:0]            i_cnt_q, i_cnt_d;
  logic [2:0]            d_cnt_q, d_cnt_d;
  logic [ADDR_WIDTH-1:0] i_addr_q;
  logic [ADDR_WIDTH-1:0] d_addr_q;
  logic                  d_we_q;
  logic [DATA_WIDTH-1:0] d_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic                  i_grant, d_grant;
  logic                  i_fire, d_fire;
  logic [ADDR_WIDTH-1:0] i_eff_addr, d_eff_addr;
  logic                  d_eff_we;
  logic [DATA_WIDTH-1:0] d_eff_wdata;
  logic                  i_in_range, d_in_range, ld_in_range;
  logic [IDX_W-1:0]      i_idx, d_idx, ld_idx;
  logic [DATA_WIDTH-1:0] i_word, d_word;
  logic                  d_mem_we, ld_mem_we;

  // In unified mode only one transaction may be in flight; data wins a tie.
  always_comb begin
    i_grant = 1'b0;
    d_grant = 1'b0;
    if (!ld_en) begin
      d_grant = (d_state_q == S_IDLE) && d_req &&
                ((UNIFIED == 0) || (i_state_q == S_IDLE));
      i_grant = (i_state_q == S_IDLE) && i_req &&
                ((UNIFIED == 0) || ((d_state_q == S_IDLE) && !d_req));
    end
  end

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    case (i_state_q)
      S_IDLE: begin
        if (i_grant) begin
          i_cnt_d   = WS;
          i_state_d = (WS == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        i_cnt_d = i_cnt_q - 3'd1;
        if (i_cnt_q == 3'd1) i_state_d = S_DONE;
      end
      S_DONE:  i_state_d = S_IDLE;
      default: i_state_d = S_IDLE;
    endcase
    if (ld_en) begin
      i_state_d = S_IDLE;
      i_cnt_d   = '0;
    end
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    case (d_state_q)
      S_IDLE: begin
        if (d_grant) begin
          d_cnt_d   = WS;
          d_state_d = (WS == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        d_cnt_d = d_cnt_q - 3'd1;
        if (d_cnt_q == 3'd1) d_state_d = S_DONE;
      end
      S_DONE:  d_state_d = S_IDLE;
      default: d_state_d = S_IDLE;
    endcase
    if (ld_en) begin
      d_state_d = S_IDLE;
      d_cnt_d   = '0;
    end
  end

  // With zero wait states DONE is entered on the accepting edge, so the live
  // inputs are used there instead of the captured copies.
  always_comb begin
    i_fire      = (i_state_d == S_DONE);
    d_fire      = (d_state_d == S_DONE);
    i_eff_addr  = (i_state_q == S_IDLE) ? i_addr  : i_addr_q;
    d_eff_addr  = (d_state_q == S_IDLE) ? d_addr  : d_addr_q;
    d_eff_we    = (d_state_q == S_IDLE) ? d_we    : d_we_q;
    d_eff_wdata = (d_state_q == S_IDLE) ? d_wdata : d_wdata_q;
    i_in_range  = ({1'b0, i_eff_addr} < DEPTH_A);
    d_in_range  = ({1'b0, d_eff_addr} < DEPTH_A);
    ld_in_range = ({1'b0, ld_addr}    < DEPTH_A);
    i_idx       = i_eff_addr[IDX_W-1:0];
    d_idx       = d_eff_addr[IDX_W-1:0];
    ld_idx      = ld_addr[IDX_W-1:0];
    ld_mem_we   = ld_en && ld_we && ld_in_range;
    d_mem_we    = d_fire && d_eff_we && d_in_range;
  end

  if (UNIFIED == 0) begin : g_split
    logic [DATA_WIDTH-1:0] pmem [DEPTH];
    logic [DATA_WIDTH-1:0] dmem [DEPTH];

    always_ff @(posedge clk) begin
      if (ld_mem_we) pmem[ld_idx] <= ld_data;
      if (d_mem_we)  dmem[d_idx]  <= d_eff_wdata;
    end

    always_comb begin
      i_word = i_in_range ? pmem[i_idx] : '0;
      d_word = d_in_range ? dmem[d_idx] : '0;
    end
  end else begin : g_unified
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (ld_mem_we)     mem[ld_idx] <= ld_data;
      else if (d_mem_we) mem[d_idx]  <= d_eff_wdata;
    end

    always_comb begin
      i_word = i_in_range ? mem[i_idx] : '0;
      d_word = d_in_range ? mem[d_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_state_q <= S_IDLE;
      d_state_q <= S_IDLE;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_we_q    <= 1'b0;
      d_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      if (i_grant) i_addr_q <= i_addr;
      if (d_grant) begin
        d_addr_q  <= d_addr;
        d_we_q    <= d_we;
        d_wdata_q <= d_wdata;
      end
      if (i_fire) i_rdata_q <= i_word;
      if (d_fire) d_rdata_q <= d_eff_we ? '0 : d_word;
    end
  end

  always_comb begin
    i_ready = (i_state_q == S_DONE);
    d_ready = (d_state_q == S_DONE);
    busy    = (i_state_q != S_IDLE) || (d_state_q != S_IDLE);
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: five instances cover split/unified storage,
// several wait-state settings and a reduced depth.
module tb_mem_system;

  localparam int NI = 5;
  localparam int K_BASE = 0;  // WS=0, split
  localparam int K_WS3  = 1;  // WS=3, split
  localparam int K_UNI  = 2;  // WS=2, unified
  localparam int K_OOR  = 3;  // WS=0, split, DEPTH=512
  localparam int K_ABT  = 4;  // WS=5, split

  localparam int unsigned WS_T  [NI] = '{0, 3, 2, 0, 5};
  localparam int unsigned UNI_T [NI] = '{0, 0, 1, 0, 0};
  localparam int unsigned DEP_T [NI] = '{1024, 1024, 1024, 512, 1024};

  logic        clk = 1'b0;
  logic        rst_n   [NI];
  logic        i_req   [NI];
  logic [9:0]  i_addr  [NI];
  logic [15:0] i_rdata [NI];
  logic        i_ready [NI];
  logic        d_req   [NI];
  logic        d_we    [NI];
  logic [9:0]  d_addr  [NI];
  logic [15:0] d_wdata [NI];
  logic [15:0] d_rdata [NI];
  logic        d_ready [NI];
  logic        ld_en   [NI];
  logic        ld_we   [NI];
  logic [9:0]  ld_addr [NI];
  logic [15:0] ld_data [NI];
  logic        busy    [NI];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_system #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (16),
      .DEPTH      (DEP_T[g]),
      .WAIT_STATES(WS_T[g]),
      .UNIFIED    (UNI_T[g])
    ) u_dut (
      .clk    (clk),
      .reset  (rst_n[g]),
      .i_req  (i_req[g]),
      .i_addr (i_addr[g]),
      .i_rdata(i_rdata[g]),
      .i_ready(i_ready[g]),
      .d_req  (d_req[g]),
      .d_we   (d_we[g]),
      .d_addr (d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]),
      .d_ready(d_ready[g]),
      .ld_en  (ld_en[g]),
      .ld_we  (ld_we[g]),
      .ld_addr(ld_addr[g]),
      .ld_data(ld_data[g]),
      .busy   (busy[g])
    );
  end

  task automatic run_fetch(input int k, input logic [9:0] a, output int lat, output logic [15:0] rd);
    i_addr[k] = a;
    i_req[k]  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!i_ready[k] && lat < 40);
    rd       = i_rdata[k];
    i_req[k] = 1'b0;
  endtask

  task automatic run_data(input int k, input logic we, input logic [9:0] a, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd);
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
    d_req[k]   = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_ready[k] && lat < 40);
    rd       = d_rdata[k];
    d_req[k] = 1'b0;
  endtask

  task automatic ld_write(input int k, input logic [9:0] a, input logic [15:0] d);
    ld_en[k]   = 1'b1;
    ld_we[k]   = 1'b1;
    ld_addr[k] = a;
    ld_data[k] = d;
    @(negedge clk);
    ld_en[k] = 1'b0;
    ld_we[k] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({i_ready[k], d_ready[k], busy[k], i_rdata[k], d_rdata[k]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ir=%b dr=%b busy=%b ird=%h drd=%h, expected all 0",
                 k, i_ready[k], d_ready[k], busy[k], i_rdata[k], d_rdata[k]);
      end
    end
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_load();
    int lat;
    logic [15:0] rd;
    ld_write(K_BASE, 10'd5, 16'hBEEF);
    run_fetch(K_BASE, 10'd5, lat, rd);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL fetch_latency: got %0d expected 1", lat);
    end
    checks++;
    if (rd !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_data: got %h expected beef", rd);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int lat;
    int t_w;
    int t_r;
    logic [15:0] rd;
    run_data(K_WS3, 1'b1, 10'd10, 16'h1234, lat, rd);
    t_w = cyc;
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ws3_write_latency: got %0d expected 4", lat);
    end
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("FAIL ws3_write_rdata: got %h expected 0000", rd);
    end
    run_data(K_WS3, 1'b0, 10'd10, 16'h0, lat, rd);
    t_r = cyc;
    checks++;
    if (t_r - t_w !== 5) begin
      errors++;
      $display("FAIL ws3_back_to_back_gap: got %0d expected 5", t_r - t_w);
    end
    checks++;
    if (rd !== 16'h1234) begin
      errors++;
      $display("FAIL ws3_read_data: got %h expected 1234", rd);
    end
    @(negedge clk);
    run_data(K_WS3, 1'b0, 10'd10, 16'h0, lat, rd);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ws3_read_latency: got %0d expected 4", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_unified_arbiter();
    int dcyc = 0;
    int icyc = 0;
    logic [15:0] ird = '0;
    d_we[K_UNI]    = 1'b1;
    d_addr[K_UNI]  = 10'd7;
    d_wdata[K_UNI] = 16'hA5A5;
    d_req[K_UNI]   = 1'b1;
    i_addr[K_UNI]  = 10'd7;
    i_req[K_UNI]   = 1'b1;
    for (int n = 1; n <= 30 && icyc == 0; n++) begin
      @(negedge clk);
      if (d_ready[K_UNI] && dcyc == 0) begin
        dcyc = n;
        d_req[K_UNI] = 1'b0;
      end
      if (i_ready[K_UNI] && icyc == 0) begin
        icyc = n;
        ird  = i_rdata[K_UNI];
        i_req[K_UNI] = 1'b0;
      end
    end
    d_req[K_UNI] = 1'b0;
    i_req[K_UNI] = 1'b0;
    checks++;
    if (dcyc !== 3) begin
      errors++;
      $display("FAIL unified_data_first: d_ready at %0d expected 3", dcyc);
    end
    checks++;
    if (icyc - dcyc !== 4) begin
      errors++;
      $display("FAIL unified_fetch_gap: got %0d expected 4", icyc - dcyc);
    end
    checks++;
    if (ird !== 16'hA5A5) begin
      errors++;
      $display("FAIL unified_fetch_data: got %h expected a5a5", ird);
    end
    @(negedge clk);
  endtask

  task automatic test_split_parallel();
    int lat;
    int dcyc = 0;
    int icyc = 0;
    logic [15:0] rd;
    logic [15:0] ird = '0;
    logic [15:0] drd = '0;
    ld_write(K_BASE, 10'd3, 16'h1111);
    run_data(K_BASE, 1'b1, 10'd3, 16'h2222, lat, rd);
    @(negedge clk);
    d_we[K_BASE]   = 1'b0;
    d_addr[K_BASE] = 10'd3;
    d_req[K_BASE]  = 1'b1;
    i_addr[K_BASE] = 10'd3;
    i_req[K_BASE]  = 1'b1;
    for (int n = 1; n <= 20 && (icyc == 0 || dcyc == 0); n++) begin
      @(negedge clk);
      if (d_ready[K_BASE] && dcyc == 0) begin
        dcyc = n;
        drd  = d_rdata[K_BASE];
        d_req[K_BASE] = 1'b0;
      end
      if (i_ready[K_BASE] && icyc == 0) begin
        icyc = n;
        ird  = i_rdata[K_BASE];
        i_req[K_BASE] = 1'b0;
      end
    end
    d_req[K_BASE] = 1'b0;
    i_req[K_BASE] = 1'b0;
    checks++;
    if (icyc !== 1 || dcyc !== 1) begin
      errors++;
      $display("FAIL split_same_cycle: i at %0d d at %0d expected both 1", icyc, dcyc);
    end
    checks++;
    if (ird !== 16'h1111) begin
      errors++;
      $display("FAIL split_fetch_data: got %h expected 1111", ird);
    end
    checks++;
    if (drd !== 16'h2222) begin
      errors++;
      $display("FAIL split_data_data: got %h expected 2222", drd);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [15:0] rd;
    run_data(K_OOR, 1'b1, 10'd88, 16'h0042, lat, rd);
    @(negedge clk);
    run_data(K_OOR, 1'b1, 10'd511, 16'h5A5A, lat, rd);
    @(negedge clk);
    run_data(K_OOR, 1'b1, 10'd600, 16'hFFFF, lat, rd);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL oor_write_completes: latency %0d expected 1", lat);
    end
    @(negedge clk);
    run_data(K_OOR, 1'b0, 10'd600, 16'h0, lat, rd);
    checks++;
    if (lat !== 1 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL oor_read: latency %0d data %h expected 1 and 0000", lat, rd);
    end
    @(negedge clk);
    run_data(K_OOR, 1'b0, 10'd88, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h0042) begin
      errors++;
      $display("FAIL oor_no_alias: got %h expected 0042", rd);
    end
    @(negedge clk);
    run_data(K_OOR, 1'b0, 10'd511, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h5A5A) begin
      errors++;
      $display("FAIL oor_last_word: got %h expected 5a5a", rd);
    end
    @(negedge clk);
    run_fetch(K_OOR, 10'd600, lat, rd);
    checks++;
    if (lat !== 1 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL oor_fetch: latency %0d data %h expected 1 and 0000", lat, rd);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat;
    int pulses;
    logic [15:0] rd;
    run_data(K_ABT, 1'b1, 10'd20, 16'h1111, lat, rd);
    @(negedge clk);

    // reset during WAIT
    d_we[K_ABT] = 1'b1; d_addr[K_ABT] = 10'd20; d_wdata[K_ABT] = 16'h2222; d_req[K_ABT] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy[K_ABT] !== 1'b1) begin
      errors++;
      $display("FAIL abort_rst_busy_before: got %b expected 1", busy[K_ABT]);
    end
    rst_n[K_ABT] = 1'b0;
    d_req[K_ABT] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[K_ABT] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_busy_after: got %b expected 0", busy[K_ABT]);
    end
    rst_n[K_ABT] = 1'b1;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (d_ready[K_ABT] || i_ready[K_ABT]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_rst_no_ready: got %0d pulses expected 0", pulses);
    end
    run_data(K_ABT, 1'b0, 10'd20, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h1111) begin
      errors++;
      $display("FAIL abort_rst_mem_unchanged: got %h expected 1111", rd);
    end
    @(negedge clk);

    // loader entry during WAIT
    d_we[K_ABT] = 1'b1; d_addr[K_ABT] = 10'd20; d_wdata[K_ABT] = 16'h3333; d_req[K_ABT] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy[K_ABT] !== 1'b1) begin
      errors++;
      $display("FAIL abort_ld_busy_before: got %b expected 1", busy[K_ABT]);
    end
    ld_en[K_ABT] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy[K_ABT] !== 1'b0) begin
      errors++;
      $display("FAIL abort_ld_busy_after: got %b expected 0", busy[K_ABT]);
    end
    @(negedge clk);
    checks++;
    if (busy[K_ABT] !== 1'b0) begin
      errors++;
      $display("FAIL abort_ld_req_ignored: busy %b expected 0", busy[K_ABT]);
    end
    ld_en[K_ABT] = 1'b0;
    d_req[K_ABT] = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (d_ready[K_ABT] || i_ready[K_ABT]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_ld_no_ready: got %0d pulses expected 0", pulses);
    end
    run_data(K_ABT, 1'b0, 10'd20, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h1111) begin
      errors++;
      $display("FAIL abort_ld_mem_unchanged: got %h expected 1111", rd);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      ld_en[k] = 1'b0; ld_we[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    test_reset();
    test_fetch_load();
    test_wait_states();
    test_unified_arbiter();
    test_split_parallel();
    test_out_of_range();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
